// File: rtl/err_report_arbiter.sv
// err_report_arbiter: collects checker error events round-robin into a log FIFO and raises a delayed sticky halt.
// Latency: accepted event appears on log_* the next cycle; halt rises FAIL_DELAY edges after the accepting edge.
// Backpressure: req_ready is withheld from everyone while the log FIFO is full; log_ready only drains the FIFO.

// err_log_fifo: small synchronous FIFO whose head output holds the last popped entry while empty.
// Latency: a push into an empty FIFO is visible on head_dat the following cycle.
// Backpressure: pushes while full and pops while empty are ignored; full is not relieved by a same-cycle pop.
module err_log_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_dat,
   input  logic         pop,
   output logic [W-1:0] head_dat,
   output logic         empty,
   output logic         full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [W-1:0]  last_dat;
   logic          do_push;
   logic          do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   // When empty, keep presenting the entry that was popped last so the trace port stays quiet.
   assign head_dat = empty ? last_dat : mem[rd_ptr];

   // Storage, power-of-two pointers that wrap naturally, occupancy and last-popped capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         last_dat <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            last_dat <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end
endmodule

module err_report_arbiter #(
   parameter int  N_REQ      = 4,
   parameter int  CODE_W     = 8,
   parameter int  DEPTH      = 4,
   parameter int  FAIL_DELAY = 50,
   localparam int SRC_W      = $clog2(N_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*CODE_W-1:0]   req_code,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      log_valid,
   output logic [SRC_W-1:0]          log_src,
   output logic [CODE_W-1:0]         log_code,
   input  logic                      log_ready,
   output logic [15:0]               err_count,
   output logic                      halt_pending,
   output logic                      halt
);
   localparam int IW       = SRC_W + 1;
   localparam int CNT_W    = (FAIL_DELAY > 1) ? $clog2(FAIL_DELAY) : 1;
   localparam int LOAD_VAL = (FAIL_DELAY > 0) ? FAIL_DELAY - 1 : 0;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_COUNT,
      ST_HALTED
   } state_t;

   logic [SRC_W-1:0]  ptr;
   logic [SRC_W-1:0]  gnt_idx;
   logic              gnt_found;
   logic [IW-1:0]     cand;
   logic [CODE_W-1:0] gnt_code;
   logic              accept;
   logic              fifo_full;
   logic              fifo_empty;
   logic [SRC_W+CODE_W-1:0] head_dat;
   state_t            state;
   logic [CNT_W-1:0]  countdown;

   // Round-robin search: first valid requester at or after ptr, wrapping past N_REQ-1.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, ptr} + IW'(k);
         if (cand >= IW'(N_REQ)) begin
            cand = cand - IW'(N_REQ);
         end
         if (!gnt_found && req_valid[cand[SRC_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[SRC_W-1:0];
         end
      end
   end

   // Select the granted requester's code slice.
   always_comb begin
      gnt_code = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_idx == SRC_W'(i)) begin
            gnt_code = req_code[i*CODE_W +: CODE_W];
         end
      end
   end

   // One-hot grant, suppressed entirely while the log FIFO is full (no pass-through on a same-cycle pop).
   always_comb begin
      req_ready = '0;
      if (gnt_found && !fifo_full) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   // A grant only exists for a valid requester, so grant-and-room is exactly the handshake.
   assign accept = gnt_found & ~fifo_full;

   // Rotate priority to just past the winner after every accepted event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (accept) begin
         ptr <= (gnt_idx == SRC_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Saturating tally of accepted error events.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (accept && (err_count != 16'hFFFF)) begin
         err_count <= err_count + 16'd1;
      end
   end

   err_log_fifo #(
      .W     (SRC_W + CODE_W),
      .DEPTH (DEPTH)
   ) u_log_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (accept),
      .push_dat ({gnt_idx, gnt_code}),
      .pop      (log_ready),
      .head_dat (head_dat),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   assign log_valid = ~fifo_empty;
   assign log_src   = head_dat[SRC_W+CODE_W-1:CODE_W];
   assign log_code  = head_dat[CODE_W-1:0];

   // Halt sequencer: the first accepted error arms the countdown; halt then latches until reset.
   // Loading FAIL_DELAY-1 and halting on the zero check puts halt FAIL_DELAY edges after the accepting edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_RUN;
         countdown    <= '0;
         halt_pending <= 1'b0;
         halt         <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (accept) begin
                  if (FAIL_DELAY == 0) begin
                     state <= ST_HALTED;
                     halt  <= 1'b1;
                  end else begin
                     state        <= ST_COUNT;
                     countdown    <= CNT_W'(LOAD_VAL);
                     halt_pending <= 1'b1;
                  end
               end
            end
            ST_COUNT: begin
               if (countdown == '0) begin
                  state        <= ST_HALTED;
                  halt_pending <= 1'b0;
                  halt         <= 1'b1;
               end else begin
                  countdown <= countdown - 1'b1;
               end
            end
            ST_HALTED: begin
               halt_pending <= 1'b0;
               halt         <= 1'b1;
            end
            default: begin
               state        <= ST_RUN;
               halt_pending <= 1'b0;
               halt         <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_err_report_arbiter.sv
// tb_err_report_arbiter: drives err_report_arbiter (FAIL_DELAY=50) and a FAIL_DELAY=0 twin from shared inputs.
// Expected values come from a queue-based reference model that is updated on every clock edge.
// Outputs are compared on the falling edge; inputs change 1 time unit after the rising edge.
module tb_err_report_arbiter;
   localparam int N_REQ      = 4;
   localparam int CODE_W     = 8;
   localparam int DEPTH      = 4;
   localparam int FAIL_DELAY = 50;
   localparam int SRC_W      = 2;
   localparam int EW         = SRC_W + CODE_W;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b1;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*CODE_W-1:0] req_code;
   logic                    log_ready;

   logic [N_REQ-1:0]  req_ready;
   logic              log_valid;
   logic [SRC_W-1:0]  log_src;
   logic [CODE_W-1:0] log_code;
   logic [15:0]       err_count;
   logic              halt_pending;
   logic              halt;

   logic [N_REQ-1:0]  z_req_ready;
   logic              z_log_valid;
   logic [SRC_W-1:0]  z_log_src;
   logic [CODE_W-1:0] z_log_code;
   logic [15:0]       z_err_count;
   logic              z_halt_pending;
   logic              z_halt;

   always #5 clk = ~clk;

   err_report_arbiter #(
      .N_REQ(N_REQ), .CODE_W(CODE_W), .DEPTH(DEPTH), .FAIL_DELAY(FAIL_DELAY)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_code(req_code),
      .req_ready(req_ready), .log_valid(log_valid), .log_src(log_src),
      .log_code(log_code), .log_ready(log_ready), .err_count(err_count),
      .halt_pending(halt_pending), .halt(halt)
   );

   err_report_arbiter #(
      .N_REQ(N_REQ), .CODE_W(CODE_W), .DEPTH(DEPTH), .FAIL_DELAY(0)
   ) dut_d0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_code(req_code),
      .req_ready(z_req_ready), .log_valid(z_log_valid), .log_src(z_log_src),
      .log_code(z_log_code), .log_ready(log_ready), .err_count(z_err_count),
      .halt_pending(z_halt_pending), .halt(z_halt)
   );

   // Reference model state
   int          m_ptr;
   logic [EW-1:0] m_q[$];
   logic [EW-1:0] m_last;
   int          m_cnt;
   int          n_edge;
   bit          m_first;
   int          m_acc_edge;
   logic [N_REQ-1:0] last_ready;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_grant();
      for (int k = 0; k < N_REQ; k++) begin
         int idx = (m_ptr + k) % N_REQ;
         if (req_valid[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic bit exp_halt(input int d);
      return m_first && (n_edge >= m_acc_edge + d);
   endfunction

   function automatic bit exp_pending(input int d);
      return m_first && (n_edge < m_acc_edge + d);
   endfunction

   function automatic int onehot_idx(input logic [N_REQ-1:0] v);
      for (int k = 0; k < N_REQ; k++) begin
         if (v[k]) return k;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr   = 0;
      m_q.delete();
      m_last  = '0;
      m_cnt   = 0;
      m_first = 1'b0;
      m_acc_edge = 0;
   endtask

   task automatic check_outputs();
      int g;
      logic [N_REQ-1:0] er;
      logic [EW-1:0] head;
      g  = exp_grant();
      er = '0;
      if (g >= 0 && m_q.size() < DEPTH) er[g] = 1'b1;
      head = (m_q.size() > 0) ? m_q[0] : m_last;
      check_eq("req_ready", req_ready, er);
      check_eq("log_valid", log_valid, m_q.size() > 0);
      check_eq("log_src", log_src, head[EW-1:CODE_W]);
      check_eq("log_code", log_code, head[CODE_W-1:0]);
      check_eq("err_count", err_count, m_cnt);
      check_eq("halt_pending", halt_pending, exp_pending(FAIL_DELAY));
      check_eq("halt", halt, exp_halt(FAIL_DELAY));
      check_eq("halt_d0", z_halt, exp_halt(0));
      check_eq("pending_d0", z_halt_pending, exp_pending(0));
      last_ready = req_ready;
   endtask

   task automatic model_update();
      int g;
      bit acc;
      bit pop;
      g   = exp_grant();
      acc = (g >= 0) && (m_q.size() < DEPTH);
      pop = (m_q.size() > 0) && log_ready;
      if (pop) m_last = m_q.pop_front();
      if (acc) begin
         m_q.push_back({g[SRC_W-1:0], req_code[g*CODE_W +: CODE_W]});
         m_ptr = (g + 1) % N_REQ;
         if (m_cnt < 65535) m_cnt++;
      end
      n_edge++;
      if (acc && !m_first) begin
         m_first    = 1'b1;
         m_acc_edge = n_edge;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic apply_reset();
      req_valid = '0;
      log_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_halt", halt, 0);
      check_eq("rst_halt_pending", halt_pending, 0);
      check_eq("rst_log_valid", log_valid, 0);
      check_eq("rst_err_count", err_count, 0);
      check_eq("rst_log_src", log_src, 0);
      check_eq("rst_log_code", log_code, 0);
      check_eq("rst_req_ready", req_ready, 0);
      check_eq("rst_halt_d0", z_halt, 0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int n_acc;
      req_valid = '0;
      req_code  = '0;
      log_ready = 1'b0;
      n_edge    = 0;
      model_reset();
      apply_reset();

      // Idle after reset
      repeat (100) cycle();

      // Single event from requester 2, held in the log until the countdown expires
      req_code = $urandom();
      req_code[2*CODE_W +: CODE_W] = 8'hA5;
      req_valid = 4'b0100;
      cycle();
      req_valid = '0;
      repeat (60) cycle();
      log_ready = 1'b1;
      repeat (3) cycle();

      // All requesters active: grants must rotate strictly
      p0 = m_ptr;
      req_valid = '1;
      for (int i = 0; i < 12; i++) begin
         req_code = $urandom();
         cycle();
         check_eq("rr_onehot", $countones(last_ready), 1);
         check_eq("rr_order", onehot_idx(last_ready), (p0 + i) % N_REQ);
      end

      // Fill the FIFO from requester 1, then release exactly one slot
      req_valid = '0;
      repeat (6) cycle();
      log_ready = 1'b0;
      req_valid = 4'b0010;
      n_acc = 0;
      for (int i = 0; i < 8; i++) begin
         req_code = $urandom();
         cycle();
         if (last_ready[1]) n_acc++;
      end
      check_eq("full_accepts", n_acc, DEPTH);
      log_ready = 1'b1;
      req_code = $urandom();
      cycle();
      if (last_ready[1]) n_acc++;
      log_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_code = $urandom();
         cycle();
         if (last_ready[1]) n_acc++;
      end
      check_eq("full_one_more", n_acc, DEPTH + 1);
      req_valid = '0;
      log_ready = 1'b1;
      repeat (8) cycle();

      // Reset in the middle of a countdown with two entries queued
      apply_reset();
      req_valid = 4'b1001;
      for (int i = 0; i < 2; i++) begin
         req_code = $urandom();
         cycle();
      end
      req_valid = '0;
      for (int i = 0; i < 100 && (n_edge - m_acc_edge) < 29; i++) cycle();
      check_eq("queued_before_reset", log_valid, 1);
      apply_reset();
      req_code = $urandom();
      req_valid = 4'b0100;
      cycle();
      req_valid = '0;
      repeat (55) cycle();

      // Random traffic with one reset in the middle
      for (int i = 0; i < 1500; i++) begin
         if (i < 750)
            req_valid = N_REQ'($urandom_range(0, 15) & $urandom_range(0, 15));
         else
            req_valid = N_REQ'($urandom_range(0, 15));
         req_code  = $urandom();
         log_ready = ($urandom_range(0, 3) != 0);
         if (i == 900) apply_reset();
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
